// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain pointer/flag controller of a dual-clock FIFO: binary and Gray read
// pointers, RAM read address, empty/almost-empty flags, fill level and underflow pulse.
module async_fifo_rd_ctrl #(
    parameter int ASIZE      = 4,
    parameter int AEMPTY_LVL = 1
) (
    input  logic             dest_clk,
    input  logic             dest_rst_n,
    input  logic             rinc,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam logic [ASIZE:0] AEMPTY_THR = (ASIZE+1)'(AEMPTY_LVL);

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic             rd_en_s;
    logic [ASIZE:0]   wbin_s;
    logic [ASIZE:0]   rbin_q, rbin_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [ASIZE:0]   rlevel_q, rlevel_d;
    logic             rempty_q, rempty_d;
    logic             raempty_q, raempty_d;
    logic             runderflow_q, runderflow_d;

    // Next-state: the freshly sampled write pointer is compared against the post-read pointer.
    always_comb begin
        rd_en_s      = rinc & ~rempty_q;
        rbin_d       = rbin_q + {{ASIZE{1'b0}}, rd_en_s};
        rptr_d       = bin2gray(rbin_d);
        wbin_s       = gray2bin(rq2_wptr);
        rlevel_d     = wbin_s - rbin_d;
        rempty_d     = (rptr_d == rq2_wptr);
        raempty_d    = (rlevel_d <= AEMPTY_THR);
        runderflow_d = rinc & rempty_q;
    end

    // State registers; every output comes straight from a flop.
    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
        if (!dest_rst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign raddr      = rbin_q[ASIZE-1:0];
    assign rptr       = rptr_q;
    assign rlevel     = rlevel_q;
    assign rempty     = rempty_q;
    assign raempty    = raempty_q;
    assign runderflow = runderflow_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Self-checking bench for async_fifo_rd_ctrl: fixed vector table, directed corner
// sequences and a randomized run against a word-count reference model.
module tb_async_fifo_rd_ctrl;

    logic       dest_clk;
    logic       dest_rst_n;
    logic       rinc;
    logic [4:0] rq2_wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       runderflow;

    async_fifo_rd_ctrl #(.ASIZE(4), .AEMPTY_LVL(1)) dut (
        .dest_clk   (dest_clk),
        .dest_rst_n (dest_rst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    initial dest_clk = 1'b0;
    always #5 dest_clk = ~dest_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: counts of words written (as seen by the reader) and words read.
    int m_wr, m_rd, m_level;
    bit m_empty, m_aempty, m_uf;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rd = 0; m_level = 0; m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rempty"},     int'(rempty),     int'(m_empty));
        chk({tag, ".raempty"},    int'(raempty),    int'(m_aempty));
        chk({tag, ".rlevel"},     int'(rlevel),     m_level);
        chk({tag, ".rptr"},       int'(rptr),       int'(gray(m_rd)));
        chk({tag, ".raddr"},      int'(raddr),      m_rd % 16);
        chk({tag, ".runderflow"}, int'(runderflow), int'(m_uf));
    endtask

    // Apply current rinc/m_wr across one clock edge, advancing the model alongside.
    task automatic tick();
        bit rd_en;
        rq2_wptr = gray(m_wr);
        rd_en    = rinc && !m_empty;
        m_uf     = rinc && m_empty;
        m_rd     = (m_rd + int'(rd_en)) % 32;
        m_level  = (m_wr - m_rd) & 31;
        m_empty  = (m_level == 0);
        m_aempty = (m_level <= 1);
        @(posedge dest_clk);
        #1;
    endtask

    task automatic do_reset();
        dest_rst_n = 1'b0;
        rinc       = 1'b0;
        m_wr       = 0;
        rq2_wptr   = 5'd0;
        model_reset();
        @(posedge dest_clk);
        @(negedge dest_clk);
        dest_rst_n = 1'b1;
    endtask

    typedef struct {
        bit rinc;
        int wr;
        bit e;
        bit ae;
        int lvl;
        int rd;
        bit uf;
    } vec_t;

    vec_t vt[10];
    logic [4:0] prev_rptr;

    initial begin
        vt[0] = '{1'b1, 0, 1'b1, 1'b1, 0, 0, 1'b1};
        vt[1] = '{1'b0, 0, 1'b1, 1'b1, 0, 0, 1'b0};
        vt[2] = '{1'b0, 1, 1'b0, 1'b1, 1, 0, 1'b0};
        vt[3] = '{1'b1, 1, 1'b1, 1'b1, 0, 1, 1'b0};
        vt[4] = '{1'b0, 2, 1'b0, 1'b1, 1, 1, 1'b0};
        vt[5] = '{1'b1, 3, 1'b0, 1'b1, 1, 2, 1'b0};
        vt[6] = '{1'b1, 3, 1'b1, 1'b1, 0, 3, 1'b0};
        vt[7] = '{1'b1, 3, 1'b1, 1'b1, 0, 3, 1'b1};
        vt[8] = '{1'b0, 5, 1'b0, 1'b0, 2, 3, 1'b0};
        vt[9] = '{1'b1, 5, 1'b0, 1'b1, 1, 4, 1'b0};

        do_reset();
        check_model("reset");
        chk("reset.rempty_const", int'(rempty), 1);
        chk("reset.rptr_const", int'(rptr), 0);

        for (int i = 0; i < 10; i++) begin
            rinc     = vt[i].rinc;
            rq2_wptr = gray(vt[i].wr);
            @(posedge dest_clk);
            #1;
            chk($sformatf("vec%0d.rempty", i),     int'(rempty),     int'(vt[i].e));
            chk($sformatf("vec%0d.raempty", i),    int'(raempty),    int'(vt[i].ae));
            chk($sformatf("vec%0d.rlevel", i),     int'(rlevel),     vt[i].lvl);
            chk($sformatf("vec%0d.rptr", i),       int'(rptr),       int'(gray(vt[i].rd)));
            chk($sformatf("vec%0d.raddr", i),      int'(raddr),      vt[i].rd % 16);
            chk($sformatf("vec%0d.runderflow", i), int'(runderflow), int'(vt[i].uf));
        end

        // Full FIFO then continuous drain.
        do_reset();
        m_wr = 16;
        tick();
        check_model("full");
        chk("full.rlevel16", int'(rlevel), 16);
        rinc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_model($sformatf("drain%0d", k));
            chk($sformatf("drain%0d.level", k), int'(rlevel), 16 - k);
            chk($sformatf("drain%0d.empty", k), int'(rempty), int'(k == 16));
            chk($sformatf("drain%0d.aempty", k), int'(raempty), int'(16 - k <= 1));
        end
        tick();
        chk("drain_over.runderflow", int'(runderflow), 1);
        chk("drain_over.rptr", int'(rptr), int'(gray(16)));

        // Stream 40 words through the pointer wrap.
        do_reset();
        prev_rptr = rptr;
        rinc = 1'b1;
        for (int c = 0; c < 60; c++) begin
            m_wr = (c + 1 < 40) ? c + 1 : 40;
            tick();
            check_model("stream");
            chk("stream.hamming", int'($countones(rptr ^ prev_rptr) <= 1), 1);
            chk("stream.level_max", int'(rlevel <= 5'd16), 1);
            prev_rptr = rptr;
        end
        chk("stream.read_all", m_rd, 40 % 32);

        // Reset asserted mid-drain with 7 words left.
        do_reset();
        m_wr = 10;
        tick();
        rinc = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("middrain.level7", int'(rlevel), 7);
        dest_rst_n = 1'b0;
        #1;
        chk("rst_async.rempty",     int'(rempty),     1);
        chk("rst_async.raempty",    int'(raempty),    1);
        chk("rst_async.rlevel",     int'(rlevel),     0);
        chk("rst_async.rptr",       int'(rptr),       0);
        chk("rst_async.raddr",      int'(raddr),      0);
        chk("rst_async.runderflow", int'(runderflow), 0);
        rinc = 1'b0;
        m_wr = 0;
        rq2_wptr = 5'd0;
        model_reset();
        @(negedge dest_clk);
        dest_rst_n = 1'b1;
        m_wr = 2;
        tick();
        check_model("restart0");
        rinc = 1'b1;
        tick();
        check_model("restart1");
        tick();
        check_model("restart2");

        // Randomized traffic; the reader never sees more than a full FIFO.
        do_reset();
        prev_rptr = rptr;
        for (int c = 0; c < 800; c++) begin
            rinc = ($urandom_range(0, 3) != 0);
            if ((((m_wr - m_rd) & 31) < 16) && ($urandom_range(0, 1) == 1)) begin
                m_wr = (m_wr + 1) % 32;
            end
            tick();
            check_model("rand");
            chk("rand.hamming", int'($countones(rptr ^ prev_rptr) <= 1), 1);
            prev_rptr = rptr;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
